// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

   localparam int UART_CLKS_PER_BIT_DEF = 16;
   localparam int UART_DATA_BITS        = 8;
   localparam int UART_BIT_IDX_W        = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   // Width of a down-counter that must hold CLKS_PER_BIT-1.
   function automatic int uart_cnt_width(input int clks);
      return (clks <= 2) ? 1 : $clog2(clks);
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: a down-counter that produces a one-cycle tick on the
// last cycle of every CLKS_PER_BIT-cycle period. Reloading on clear lines
// the first period up with the frame start.
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int             CNT_W  = uart_cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   // Count down while enabled, reload at terminal count or on clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= RELOAD;
      end else if (enable) begin
         if (cnt == '0) begin
            cnt <= RELOAD;
         end else begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   assign tick = enable && (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits, MSB first, one start and one stop period.
// Build option: define UART_TX_STOP_HIGH_EN to drive the stop period high
// (standard stop bit); without it the stop period is driven low.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high, ready high, waiting for start
// START | start bit period (line low)
// DATA  | 8 data bit periods, data_q[bit_idx] with bit_idx 7 down to 0
// STOP  | trailing stop period, level set by build option
//
// Both outputs are registered from the current state, so the line lags the
// state by one clock: accepting edge E0 leaves the line high, the start bit
// appears after E1, and ready returns one edge after the FSM re-enters IDLE.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [UART_DATA_BITS-1:0] data,
   input  logic                      start,
   output logic                      serial_data,
   output logic                      ready
);

`ifdef UART_TX_STOP_HIGH_EN
   localparam logic STOP_LEVEL = 1'b1;
`else
   localparam logic STOP_LEVEL = 1'b0;
`endif

   localparam logic [UART_BIT_IDX_W-1:0] FIRST_BIT_IDX = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

   uart_state_e                state;
   uart_state_e                state_next;
   logic [UART_DATA_BITS-1:0]  data_q;
   logic [UART_BIT_IDX_W-1:0]  bit_idx;
   logic                       bit_tick;
   logic                       accept;
   logic                       serial_next;
   logic                       ready_next;

   assign accept = (state == IDLE) && start;

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .clear  (accept),
      .enable (state != IDLE),
      .tick   (bit_tick)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; start is only looked at in IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = START;
         START:   if (bit_tick) state_next = DATA;
         DATA:    if (bit_tick && (bit_idx == '0)) state_next = STOP;
         STOP:    if (bit_tick) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Byte latch on acceptance and bit-index down-counter across DATA.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         bit_idx <= '0;
      end else if (accept) begin
         data_q  <= data;
         bit_idx <= FIRST_BIT_IDX;
      end else if ((state == DATA) && bit_tick && (bit_idx != '0)) begin
         bit_idx <= bit_idx - UART_BIT_IDX_W'(1);
      end
   end

   // Output decode from the current state.
   always_comb begin
      serial_next = 1'b1;
      ready_next  = 1'b0;
      case (state)
         IDLE: begin
            serial_next = 1'b1;
            ready_next  = 1'b1;
         end
         START:   serial_next = 1'b0;
         DATA:    serial_next = data_q[bit_idx];
         STOP:    serial_next = STOP_LEVEL;
         default: serial_next = 1'b1;
      endcase
   end

   // Output registers; reset holds the line idle but not ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         serial_data <= 1'b1;
         ready       <= 1'b0;
      end else begin
         serial_data <= serial_next;
         ready       <= ready_next;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: per-cycle expected {serial_data, ready}
// values are queued as stimulus is applied and compared on falling edges.
module tb_uart_tx;

   localparam int CPB = 16;

`ifdef UART_TX_STOP_HIGH_EN
   localparam logic STOP_EXP = 1'b1;
`else
   localparam logic STOP_EXP = 1'b0;
`endif

   typedef struct packed {
      logic serial;
      logic rdy;
   } exp_t;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       start = 1'b0;
   logic [7:0] data  = 8'h00;
   logic       serial_data;
   logic       ready;

   exp_t  exp_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   string phase = "init";

   always #5 clk = ~clk;

   uart_tx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .data        (data),
      .start       (start),
      .serial_data (serial_data),
      .ready       (ready)
   );

   task automatic chk(input string tag, input logic obs, input logic exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %b, want %b at t=%0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic push(input logic s, input logic r, input int n);
      exp_t e;
      e.serial = s;
      e.rdy    = r;
      for (int i = 0; i < n; i++) exp_q.push_back(e);
   endtask

   task automatic push_frame(input logic [7:0] b);
      push(1'b0, 1'b0, CPB);
      for (int k = 7; k >= 0; k--) push(b[k], 1'b0, CPB);
      push(STOP_EXP, 1'b0, CPB);
   endtask

   // One clock; compare against the oldest queued expectation.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({phase, ".serial"}, serial_data, e.serial);
         chk({phase, ".ready"},  ready,       e.rdy);
      end
   endtask

   task automatic drain();
      while (exp_q.size() > 0) cycle();
   endtask

   // Pulse start for one cycle with byte b, then expect idle_n idle cycles.
   task automatic send_frame(input logic [7:0] b, input int idle_n);
      data  = b;
      start = 1'b1;
      push(1'b1, 1'b1, 1);
      push_frame(b);
      push(1'b1, 1'b1, idle_n);
      cycle();
      start = 1'b0;
      drain();
   endtask

   initial begin
      // Reset held with active-looking inputs.
      rst   = 1'b1;
      start = 1'b1;
      data  = 8'hD5;
      phase = "reset_hold";
      push(1'b1, 1'b0, 600);
      drain();

      // Release: ready rises on the first edge after deassertion.
      rst   = 1'b0;
      start = 1'b0;
      phase = "reset_release";
      push(1'b1, 1'b1, 10);
      drain();

      phase = "single_d5";
      send_frame(8'hD5, 300);

      phase = "two_byte_d5";
      send_frame(8'hD5, 100);
      phase = "two_byte_bd";
      send_frame(8'hBD, 20);

      // Mid-frame request with different data must not disturb the frame.
      phase = "mid_start";
      data  = 8'hD5;
      start = 1'b1;
      push(1'b1, 1'b1, 1);
      push_frame(8'hD5);
      push(1'b1, 1'b1, 100);
      cycle();
      start = 1'b0;
      repeat (80) cycle();
      data  = 8'hFF;
      start = 1'b1;
      cycle();
      start = 1'b0;
      drain();

      // Start held high: next frame accepted on the first IDLE edge.
      phase = "held_start";
      data  = 8'hD5;
      start = 1'b1;
      push(1'b1, 1'b1, 1);
      push_frame(8'hD5);
      push(1'b1, 1'b1, 1);
      push_frame(8'hBD);
      push(1'b1, 1'b1, 20);
      cycle();
      data = 8'hBD;
      for (int i = 0; i < 200; i++) cycle();
      start = 1'b0;
      drain();

      // Reset mid-frame aborts at once.
      phase = "mid_reset";
      data  = 8'hD5;
      start = 1'b1;
      push(1'b1, 1'b1, 1);
      push_frame(8'hD5);
      cycle();
      start = 1'b0;
      repeat (50) cycle();
      rst = 1'b1;
      #1;
      exp_q.delete();
      chk("mid_reset.serial_now", serial_data, 1'b1);
      chk("mid_reset.ready_now",  ready,       1'b0);
      push(1'b1, 1'b0, 5);
      drain();
      rst   = 1'b0;
      phase = "mid_reset_release";
      push(1'b1, 1'b1, 10);
      drain();

      phase = "after_reset_d5";
      send_frame(8'hD5, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
